// File: rtl/accum_alu_seq_if.sv
// ---------------------------------------------------------------------------
// accum_alu_seq_if
// Groups the operand/opcode/handshake bus of the accumulator ALU.
//   Data     : operand A (W bits)
//   Function : 3-bit opcode, sampled together with Go
//   Go       : execute request
//   ALUout   : registered 2W-bit result (low W bits are operand B)
//   Busy     : multiply in progress
//   Done     : one-cycle completion pulse
//   Overflow : sticky carry-out flag from ACC
// The master modport is the requester; the slave modport is the ALU.
// ---------------------------------------------------------------------------
interface accum_alu_seq_if #(
    parameter int W = 4
);
    logic [W-1:0]   Data;
    logic [2:0]     Function;
    logic           Go;
    logic [2*W-1:0] ALUout;
    logic           Busy;
    logic           Done;
    logic           Overflow;

    modport master (
        output Data,
        output Function,
        output Go,
        input  ALUout,
        input  Busy,
        input  Done,
        input  Overflow
    );

    modport slave (
        input  Data,
        input  Function,
        input  Go,
        output ALUout,
        output Busy,
        output Done,
        output Overflow
    );
endinterface

// File: rtl/accum_alu_seq.sv
// ---------------------------------------------------------------------------
// accum_alu_seq
// Parametrised accumulator ALU. The low W bits of the registered result
// feed back as operand B; operand A comes from the bus Data field.
// Eight opcodes; MUL is an iterative shift-add taking W cycles with a
// Busy/Done handshake. Overflow is a sticky carry-out flag set by ACC.
// Ports:
//   Clock   : rising-edge clock
//   Reset_b : asynchronous active-low reset
//   bus     : accum_alu_seq_if slave (Data, Function, Go, ALUout, Busy,
//             Done, Overflow); the interface W must match this module's W
// ---------------------------------------------------------------------------
module accum_alu_seq #(
    parameter int W = 4
) (
    input  logic          Clock,
    input  logic          Reset_b,
    accum_alu_seq_if.slave bus
);
    localparam int CW = $clog2(W + 1);

    typedef enum logic {
        IDLE,
        MUL
    } state_t;

    state_t          r_state, w_stateNext;
    logic [2*W-1:0]  r_aluOut, w_aluOutNext;
    logic [2*W-1:0]  r_mcand, w_mcandNext;
    logic [2*W-1:0]  r_mulAcc, w_mulAccNext;
    logic [W-1:0]    r_mplier, w_mplierNext;
    logic [CW-1:0]   r_count, w_countNext;
    logic            r_busy, w_busyNext;
    logic            r_done, w_doneNext;
    logic            r_overflow, w_overflowNext;

    logic [2*W-1:0]  w_aExt;
    logic [2*W-1:0]  w_bExt;
    logic [2*W:0]    w_accSum;
    logic [2*W-1:0]  w_partial;

    // Zero-extended operands; ACC keeps one extra bit to catch the carry.
    // w_partial is the multiply accumulator after the current iteration,
    // adding the shifted multiplicand only when the multiplier LSB is set.
    assign w_aExt    = {{W{1'b0}}, bus.Data};
    assign w_bExt    = {{W{1'b0}}, r_aluOut[W-1:0]};
    assign w_accSum  = {1'b0, r_aluOut} + {1'b0, w_aExt};
    assign w_partial = r_mulAcc + (r_mplier[0] ? r_mcand : '0);

    // Next-state and next-output logic. Everything holds by default and
    // Done drops unless an operation completes on this edge. In MUL the
    // bus inputs are not looked at, so requests made mid-multiply vanish.
    always_comb begin
        w_stateNext    = r_state;
        w_aluOutNext   = r_aluOut;
        w_mcandNext    = r_mcand;
        w_mulAccNext   = r_mulAcc;
        w_mplierNext   = r_mplier;
        w_countNext    = r_count;
        w_busyNext     = r_busy;
        w_doneNext     = 1'b0;
        w_overflowNext = r_overflow;

        case (r_state)
            IDLE: begin
                if (bus.Go) begin
                    w_doneNext = 1'b1;
                    case (bus.Function)
                        3'd0: w_aluOutNext = w_aExt + w_bExt;
                        3'd1: begin
                            w_stateNext  = MUL;
                            w_busyNext   = 1'b1;
                            w_doneNext   = 1'b0;
                            w_mcandNext  = w_aExt;
                            w_mplierNext = r_aluOut[W-1:0];
                            w_mulAccNext = '0;
                            w_countNext  = '0;
                        end
                        3'd2: w_aluOutNext = w_bExt << bus.Data;
                        3'd3: w_aluOutNext = r_aluOut;
                        3'd4: w_aluOutNext = w_bExt - w_aExt;
                        3'd5: w_aluOutNext = w_bExt >> bus.Data;
                        3'd6: begin
                            w_aluOutNext = w_accSum[2*W-1:0];
                            if (w_accSum[2*W]) begin
                                w_overflowNext = 1'b1;
                            end
                        end
                        default: begin
                            w_aluOutNext   = '0;
                            w_overflowNext = 1'b0;
                        end
                    endcase
                end
            end
            MUL: begin
                w_mulAccNext = w_partial;
                w_mcandNext  = r_mcand << 1;
                w_mplierNext = r_mplier >> 1;
                w_countNext  = r_count + 1'b1;
                if (r_count == CW'(W - 1)) begin
                    w_aluOutNext = w_partial;
                    w_busyNext   = 1'b0;
                    w_doneNext   = 1'b1;
                    w_stateNext  = IDLE;
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    // State and datapath registers. Reset aborts any multiply in flight
    // and leaves no trace of a partial product.
    always_ff @(posedge Clock or negedge Reset_b) begin
        if (!Reset_b) begin
            r_state    <= IDLE;
            r_aluOut   <= '0;
            r_mcand    <= '0;
            r_mulAcc   <= '0;
            r_mplier   <= '0;
            r_count    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_aluOut   <= w_aluOutNext;
            r_mcand    <= w_mcandNext;
            r_mulAcc   <= w_mulAccNext;
            r_mplier   <= w_mplierNext;
            r_count    <= w_countNext;
            r_busy     <= w_busyNext;
            r_done     <= w_doneNext;
            r_overflow <= w_overflowNext;
        end
    end

    assign bus.ALUout   = r_aluOut;
    assign bus.Busy     = r_busy;
    assign bus.Done     = r_done;
    assign bus.Overflow = r_overflow;
endmodule

// File: tb/tb_accum_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_accum_alu_seq
// Self-checking bench for accum_alu_seq. A W=4 instance runs a table of
// opcode vectors whose expected results go through a scoreboard queue,
// followed by hand-written multiply and reset-mid-multiply sequences.
// A second W=8 instance checks a wide multiply.
// ---------------------------------------------------------------------------
module tb_accum_alu_seq;
    logic clk;
    logic rst_b;

    int nVec = 0;
    int nErr = 0;

    accum_alu_seq_if #(.W(4)) bus4 ();
    accum_alu_seq_if #(.W(8)) bus8 ();

    accum_alu_seq #(.W(4)) u_dut4 (
        .Clock   (clk),
        .Reset_b (rst_b),
        .bus     (bus4)
    );

    accum_alu_seq #(.W(8)) u_dut8 (
        .Clock   (clk),
        .Reset_b (rst_b),
        .bus     (bus8)
    );

    typedef struct {
        logic [2:0]  func;
        logic [3:0]  data;
        logic [15:0] alu;
        logic        ovf;
    } vec_t;

    typedef struct {
        logic [15:0] alu;
        logic        ovf;
    } exp_t;

    exp_t sbq[$];
    vec_t vecs[25];

    // Free-running 10-time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so a stuck handshake can never hang the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [15:0] act,
                               input logic [15:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one accepted operation on the W=4 DUT, queue its expected result,
    // wait (bounded) for Done, then pop and compare. A last check makes sure
    // Done lasted only one cycle.
    task automatic applyStimulus(input logic [2:0] func, input logic [3:0] data,
                                 input logic [15:0] expAlu, input logic expOvf,
                                 input string name);
        exp_t e;
        int   cycles;
        @(negedge clk);
        bus4.Go       = 1'b1;
        bus4.Function = func;
        bus4.Data     = data;
        e.alu = expAlu;
        e.ovf = expOvf;
        sbq.push_back(e);
        @(negedge clk);
        bus4.Go = 1'b0;
        cycles  = 0;
        while (!bus4.Done && cycles < 12) begin
            @(negedge clk);
            cycles++;
        end
        if (!bus4.Done) begin
            checkOutput({name, " done-timeout"}, 16'd0, 16'd1);
            void'(sbq.pop_front());
        end else begin
            e = sbq.pop_front();
            checkOutput({name, " ALUout"}, {8'd0, bus4.ALUout}, e.alu);
            checkOutput({name, " Overflow"}, {15'd0, bus4.Overflow}, {15'd0, e.ovf});
            checkOutput({name, " Busy"}, {15'd0, bus4.Busy}, 16'd0);
        end
        @(negedge clk);
        checkOutput({name, " Done single pulse"}, {15'd0, bus4.Done}, 16'd0);
    endtask

    initial begin
        int cycles;
        int busyCnt;

        // Vector table run in order on the W=4 DUT; B is the previous result.
        vecs[0]  = '{3'd0, 4'd5,  16'h0005, 1'b0};
        vecs[1]  = '{3'd0, 4'd3,  16'h0008, 1'b0};
        vecs[2]  = '{3'd7, 4'd0,  16'h0000, 1'b0};
        vecs[3]  = '{3'd0, 4'd3,  16'h0003, 1'b0};
        vecs[4]  = '{3'd2, 4'd5,  16'h0060, 1'b0};
        vecs[5]  = '{3'd7, 4'd0,  16'h0000, 1'b0};
        vecs[6]  = '{3'd0, 4'd15, 16'h000F, 1'b0};
        vecs[7]  = '{3'd5, 4'd2,  16'h0003, 1'b0};
        vecs[8]  = '{3'd2, 4'd8,  16'h0000, 1'b0};
        vecs[9]  = '{3'd0, 4'd2,  16'h0002, 1'b0};
        vecs[10] = '{3'd4, 4'd5,  16'h00FD, 1'b0};
        vecs[11] = '{3'd3, 4'd7,  16'h00FD, 1'b0};
        vecs[12] = '{3'd7, 4'd0,  16'h0000, 1'b0};
        vecs[13] = '{3'd4, 4'd1,  16'h00FF, 1'b0};
        vecs[14] = '{3'd6, 4'd1,  16'h0000, 1'b1};
        vecs[15] = '{3'd0, 4'd4,  16'h0004, 1'b1};
        vecs[16] = '{3'd6, 4'd3,  16'h0007, 1'b1};
        vecs[17] = '{3'd3, 4'd0,  16'h0007, 1'b1};
        vecs[18] = '{3'd7, 4'd0,  16'h0000, 1'b0};
        vecs[19] = '{3'd0, 4'd9,  16'h0009, 1'b0};
        vecs[20] = '{3'd5, 4'd9,  16'h0000, 1'b0};
        vecs[21] = '{3'd0, 4'd9,  16'h0009, 1'b0};
        vecs[22] = '{3'd6, 4'd5,  16'h000E, 1'b0};
        vecs[23] = '{3'd1, 4'd3,  16'h002A, 1'b0};
        vecs[24] = '{3'd7, 4'd0,  16'h0000, 1'b0};

        rst_b         = 1'b0;
        bus4.Go       = 1'b0;
        bus4.Function = 3'd0;
        bus4.Data     = 4'd0;
        bus8.Go       = 1'b0;
        bus8.Function = 3'd0;
        bus8.Data     = 8'd0;
        #12;
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        checkOutput("reset ALUout", {8'd0, bus4.ALUout}, 16'h0000);
        checkOutput("reset Busy", {15'd0, bus4.Busy}, 16'd0);
        checkOutput("reset Done", {15'd0, bus4.Done}, 16'd0);
        checkOutput("reset Overflow", {15'd0, bus4.Overflow}, 16'd0);

        for (int i = 0; i < 25; i++) begin
            applyStimulus(vecs[i].func, vecs[i].data, vecs[i].alu, vecs[i].ovf,
                          $sformatf("vec%0d", i));
        end

        // Cycle-accurate multiply 7 x 9 with a Go+ADD request held during it.
        applyStimulus(3'd0, 4'd9, 16'h0009, 1'b0, "mul setup B=9");
        @(negedge clk);
        bus4.Go       = 1'b1;
        bus4.Function = 3'd1;
        bus4.Data     = 4'd7;
        @(negedge clk);
        bus4.Function = 3'd0;
        bus4.Data     = 4'd1;
        for (int c = 0; c < 4; c++) begin
            checkOutput($sformatf("mul busy c%0d", c), {15'd0, bus4.Busy}, 16'd1);
            checkOutput($sformatf("mul hold c%0d", c), {8'd0, bus4.ALUout}, 16'h0009);
            checkOutput($sformatf("mul no done c%0d", c), {15'd0, bus4.Done}, 16'd0);
            @(negedge clk);
        end
        bus4.Go = 1'b0;
        checkOutput("mul result", {8'd0, bus4.ALUout}, 16'h003F);
        checkOutput("mul done", {15'd0, bus4.Done}, 16'd1);
        checkOutput("mul busy fell", {15'd0, bus4.Busy}, 16'd0);
        @(negedge clk);
        checkOutput("mul done pulse", {15'd0, bus4.Done}, 16'd0);
        checkOutput("mul ignored ADD", {8'd0, bus4.ALUout}, 16'h003F);

        // Reset asserted two cycles into a multiply, between clock edges.
        @(negedge clk);
        bus4.Go       = 1'b1;
        bus4.Function = 3'd1;
        bus4.Data     = 4'd2;
        @(negedge clk);
        bus4.Go = 1'b0;
        checkOutput("pre-reset busy", {15'd0, bus4.Busy}, 16'd1);
        @(posedge clk);
        #3;
        rst_b = 1'b0;
        #1;
        checkOutput("async reset ALUout", {8'd0, bus4.ALUout}, 16'h0000);
        checkOutput("async reset Busy", {15'd0, bus4.Busy}, 16'd0);
        checkOutput("async reset Done", {15'd0, bus4.Done}, 16'd0);
        checkOutput("async reset Overflow", {15'd0, bus4.Overflow}, 16'd0);
        @(negedge clk);
        rst_b = 1'b1;
        applyStimulus(3'd0, 4'd6, 16'h0006, 1'b0, "post-reset ADD");

        // Wide instance: 15 x 15 with W=8 takes eight Busy cycles.
        @(negedge clk);
        bus8.Go       = 1'b1;
        bus8.Function = 3'd0;
        bus8.Data     = 8'd15;
        @(negedge clk);
        bus8.Go = 1'b0;
        checkOutput("w8 ADD", bus8.ALUout, 16'h000F);
        @(negedge clk);
        bus8.Go       = 1'b1;
        bus8.Function = 3'd1;
        bus8.Data     = 8'd15;
        @(negedge clk);
        bus8.Go = 1'b0;
        cycles  = 0;
        busyCnt = 0;
        while (!bus8.Done && cycles < 30) begin
            if (bus8.Busy) busyCnt++;
            @(negedge clk);
            cycles++;
        end
        checkOutput("w8 mul done seen", {15'd0, bus8.Done}, 16'd1);
        checkOutput("w8 mul result", bus8.ALUout, 16'h00E1);
        checkOutput("w8 busy cycles", 16'(busyCnt), 16'd8);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end
endmodule
